// File: rtl/jogo_pkg.sv
// Shared definitions for the game input stage: FSM state codes and key-pattern helpers.
package jogo_pkg;

    localparam logic [1:0] ESPERA = 2'd0;
    localparam logic [1:0] FILTRA = 2'd1;
    localparam logic [1:0] VALIDA = 2'd2;
    localparam logic [1:0] SOLTA  = 2'd3;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Key/timer bundle between the upstream driver (master) and detector_jogada (slave).
interface detector_jogada_if;

    logic [3:0] chaves;
    logic       zera_timer;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       tem_jogada;
    logic       fim_timer;
    logic [3:0] db_estado;

    modport master (
        output chaves, zera_timer,
        input  jogada, jogada_feita, tem_jogada, fim_timer, db_estado
    );

    modport slave (
        input  chaves, zera_timer,
        output jogada, jogada_feita, tem_jogada, fim_timer, db_estado
    );

endinterface

// File: rtl/contador_timeout.sv
// Per-play timeout counter with a sticky terminal flag; clear beats count and terminal.
module contador_timeout #(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    // Flag rises on the edge that loads TIMEOUT_CICLOS-1, so it is seen one edge earlier.
    localparam logic [TW-1:0] T_PENULT = TW'(TIMEOUT_CICLOS - 2);

    logic [TW-1:0] t_q, t_d;
    logic          fim_q, fim_d;

    always_comb begin
        t_d   = t_q;
        fim_d = fim_q;
        if (clear) begin
            t_d   = '0;
            fim_d = 1'b0;
        end else if (enable && !fim_q) begin
            t_d = t_q + 1'b1;
            if (t_q == T_PENULT) begin
                fim_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_q   <= '0;
            fim_q <= 1'b0;
        end else begin
            t_q   <= t_d;
            fim_q <= fim_d;
        end
    end

    assign fim = fim_q;

endmodule

// File: rtl/detector_jogada.sv
// Synchronizes and debounces the four keys, accepts one-hot presses and pulses jogada_feita.
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 4,
    parameter int unsigned TIMEOUT_CICLOS  = 5000
) (
    input logic              clock,
    input logic              reset,
    detector_jogada_if.slave bus
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS);

    logic [3:0]    sync_q, chaves_s;
    logic [1:0]    estado_q, estado_d;
    logic [3:0]    amostra_q, amostra_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          fim;

    always_comb begin
        estado_d  = estado_q;
        amostra_d = amostra_q;
        cnt_d     = cnt_q;
        jogada_d  = jogada_q;
        case (estado_q)
            ESPERA: begin
                if (eh_one_hot(chaves_s)) begin
                    estado_d  = FILTRA;
                    amostra_d = chaves_s;
                    cnt_d     = CW'(1);
                end else if (chaves_s != 4'b0000) begin
                    estado_d = SOLTA;
                    cnt_d    = '0;
                end
            end
            FILTRA: begin
                if (chaves_s != amostra_q) begin
                    estado_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_FIM) begin
                        estado_d = VALIDA;
                        jogada_d = amostra_q;
                    end
                end
            end
            VALIDA: begin
                estado_d = SOLTA;
                cnt_d    = '0;
            end
            SOLTA: begin
                // Any key activity restarts the release window.
                if (chaves_s != 4'b0000) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_FIM) begin
                        estado_d = ESPERA;
                    end
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            chaves_s  <= '0;
            estado_q  <= ESPERA;
            amostra_q <= '0;
            cnt_q     <= '0;
            jogada_q  <= '0;
        end else begin
            sync_q    <= bus.chaves;
            chaves_s  <= sync_q;
            estado_q  <= estado_d;
            amostra_q <= amostra_d;
            cnt_q     <= cnt_d;
            jogada_q  <= jogada_d;
        end
    end

    contador_timeout #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (bus.zera_timer || (estado_q == VALIDA)),
        .enable (1'b1),
        .fim    (fim)
    );

    assign bus.jogada       = jogada_q;
    assign bus.jogada_feita = (estado_q == VALIDA);
    assign bus.tem_jogada   = |chaves_s;
    assign bus.fim_timer    = fim;
    assign bus.db_estado    = {2'b00, estado_q};

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CICLOS=4 and TIMEOUT_CICLOS=20.
module tb_detector_jogada;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] exp_db [16];

    detector_jogada_if bus_if ();

    detector_jogada #(
        .DEBOUNCE_CICLOS(4),
        .TIMEOUT_CICLOS (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Press from idle; edge 0 is the first edge that samples the key.
    task automatic press(input logic [3:0] key, input string tag);
        for (int i = 0; i < 8; i++) begin
            bus_if.chaves = key;
            step();
            check({tag, " pulse"}, 32'(bus_if.jogada_feita), 32'(i == 5));
        end
        check({tag, " jogada"}, 32'(bus_if.jogada), 32'(key));
    endtask

    task automatic release_keys();
        bus_if.chaves = 4'b0000;
        repeat (8) step();
        check("idle after release", 32'(bus_if.db_estado), 32'd0);
    endtask

    initial begin
        exp_db = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3,
                   4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0};
        reset             = 1'b1;
        bus_if.chaves     = 4'b0000;
        bus_if.zera_timer = 1'b0;
        step();
        step();
        check("reset jogada", 32'(bus_if.jogada), 32'd0);
        check("reset pulse", 32'(bus_if.jogada_feita), 32'd0);
        check("reset tem", 32'(bus_if.tem_jogada), 32'd0);
        check("reset fim", 32'(bus_if.fim_timer), 32'd0);
        check("reset estado", 32'(bus_if.db_estado), 32'd0);
        reset = 1'b0;

        // Timeout from reset, stickiness, clear and re-arm.
        repeat (18) step();
        check("fim before edge 19", 32'(bus_if.fim_timer), 32'd0);
        step();
        check("fim at edge 19", 32'(bus_if.fim_timer), 32'd1);
        repeat (5) step();
        check("fim sticky", 32'(bus_if.fim_timer), 32'd1);
        bus_if.zera_timer = 1'b1;
        step();
        bus_if.zera_timer = 1'b0;
        check("fim cleared by zera", 32'(bus_if.fim_timer), 32'd0);
        repeat (18) step();
        check("fim before k+19", 32'(bus_if.fim_timer), 32'd0);
        step();
        check("fim at k+19", 32'(bus_if.fim_timer), 32'd1);

        // Clean press: 10 cycles held, then released.
        for (int i = 0; i < 16; i++) begin
            bus_if.chaves = (i < 10) ? 4'b0100 : 4'b0000;
            step();
            check("clean pulse", 32'(bus_if.jogada_feita), 32'(i == 5));
            check("clean estado", 32'(bus_if.db_estado), 32'(exp_db[i]));
            if (i == 0) check("tem before sync", 32'(bus_if.tem_jogada), 32'd0);
            if (i == 1) check("tem after sync", 32'(bus_if.tem_jogada), 32'd1);
            if (i == 4) check("jogada before accept", 32'(bus_if.jogada), 32'd0);
            if (i == 5) check("jogada at accept", 32'(bus_if.jogada), 32'h4);
        end
        check("jogada holds after release", 32'(bus_if.jogada), 32'h4);

        // Bounce: toggle every 2 cycles for 12 cycles, then hold.
        for (int i = 0; i < 22; i++) begin
            bus_if.chaves = (i >= 12) ? 4'b0010 : ((((i / 2) % 2) == 0) ? 4'b0010 : 4'b0000);
            step();
            check("bounce pulse", 32'(bus_if.jogada_feita), 32'(i == 17));
        end
        check("bounce jogada", 32'(bus_if.jogada), 32'h2);
        release_keys();

        // Two keys, then one key without a full release.
        for (int i = 0; i < 12; i++) begin
            bus_if.chaves = (i < 4) ? 4'b0011 : 4'b0001;
            step();
            check("two keys pulse", 32'(bus_if.jogada_feita), 32'd0);
            if (i >= 2) check("two keys estado", 32'(bus_if.db_estado), 32'd3);
        end
        bus_if.chaves = 4'b0000;
        for (int j = 0; j < 6; j++) begin
            step();
            if (j == 4) check("release window open", 32'(bus_if.db_estado), 32'd3);
            if (j == 5) check("release window done", 32'(bus_if.db_estado), 32'd0);
        end
        press(4'b1000, "after two keys");
        release_keys();

        // VALIDA lands on the timer's terminal edge: clear wins.
        bus_if.zera_timer = 1'b1;
        step();
        bus_if.zera_timer = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 26; i++) begin
            bus_if.chaves = 4'b0010;
            step();
            if (i < 8) check("coincide pulse", 32'(bus_if.jogada_feita), 32'(i == 5));
            if (i == 6) check("coincide fim held low", 32'(bus_if.fim_timer), 32'd0);
            if (i == 24) check("coincide t restarted", 32'(bus_if.fim_timer), 32'd0);
            if (i == 25) check("coincide fim after 19", 32'(bus_if.fim_timer), 32'd1);
        end
        release_keys();

        // zera_timer during FILTRA leaves the press intact.
        for (int i = 0; i < 8; i++) begin
            bus_if.chaves     = 4'b0100;
            bus_if.zera_timer = (i == 3);
            step();
            check("zera in filtra pulse", 32'(bus_if.jogada_feita), 32'(i == 5));
        end
        bus_if.zera_timer = 1'b0;
        check("zera in filtra jogada", 32'(bus_if.jogada), 32'h4);
        release_keys();

        // Reset mid-FILTRA with the key held.
        for (int i = 0; i < 4; i++) begin
            bus_if.chaves = 4'b0001;
            step();
        end
        check("in filtra before reset", 32'(bus_if.db_estado), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async reset jogada", 32'(bus_if.jogada), 32'd0);
        check("async reset pulse", 32'(bus_if.jogada_feita), 32'd0);
        check("async reset tem", 32'(bus_if.tem_jogada), 32'd0);
        check("async reset fim", 32'(bus_if.fim_timer), 32'd0);
        check("async reset estado", 32'(bus_if.db_estado), 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post reset pulse", 32'(bus_if.jogada_feita), 32'(i == 5));
            if (i == 4) check("post reset jogada early", 32'(bus_if.jogada), 32'd0);
        end
        check("post reset jogada", 32'(bus_if.jogada), 32'h1);
        release_keys();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
